// File: rtl/vga_image_writer_pkg.sv
// vga_image_writer_pkg
// Shared definitions for the processor-side image_word producer:
//   - image_word field positions
//   - FSM state encoding
//   - request entry layout held in the request FIFO
//   - small helpers for packing the image word and sizing the cycle counter
package vga_image_writer_pkg;

    localparam int unsigned WEN_BIT   = 23;
    localparam int unsigned COLOR_MSB = 22;
    localparam int unsigned COLOR_LSB = 15;
    localparam int unsigned ADDR_MSB  = 14;

    localparam int unsigned ADDR_W  = ADDR_MSB + 1;
    localparam int unsigned COLOR_W = COLOR_MSB - COLOR_LSB + 1;
    localparam int unsigned LEN_W   = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ASSERT,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic               fill;
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
        logic [LEN_W-1:0]   len;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [31:0] pack_word(input logic wen, input logic [COLOR_W-1:0] color,
                                              input logic [ADDR_W-1:0] addr);
        logic [31:0] w;
        w                     = '0;
        w[WEN_BIT]            = wen;
        w[COLOR_MSB:COLOR_LSB] = color;
        w[ADDR_MSB:0]         = addr;
        return w;
    endfunction

endpackage

// File: rtl/vga_image_writer_if.sv
// vga_image_writer_if
// Request handshake between the IO/memory-mapped path (master) and the
// image writer (slave).
//   req_valid  master->slave  request present
//   req_ready  slave->master  FIFO can accept
//   req_fill   master->slave  0 = single pixel, 1 = run fill
//   req_addr   master->slave  first image RAM address
//   req_color  master->slave  palette index
//   req_len    master->slave  fill length (ignored for single pixel)
interface vga_image_writer_if;
    import vga_image_writer_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_fill;
    logic [ADDR_W-1:0]  req_addr;
    logic [COLOR_W-1:0] req_color;
    logic [LEN_W-1:0]   req_len;

    modport master (
        output req_valid, req_fill, req_addr, req_color, req_len,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_fill, req_addr, req_color, req_len,
        output req_ready
    );

endinterface

// File: rtl/vga_image_writer_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with register storage; the head entry is presented
// directly from the storage registers (first-word fall-through).
//   clk, rst   clock, asynchronous active-high reset
//   i_push     write i_data (ignored when full, even if popping this cycle)
//   i_pop      discard head entry (ignored when empty)
//   i_data     write data
//   o_data     head entry
//   o_full     DEPTH entries held
//   o_empty    no entries held
module sync_fifo #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_image_writer.sv
// vga_image_writer
// Buffers pixel-write / run-fill requests and serialises every pixel onto
// image_word as a SETUP / ASSERT / GAP frame so the VGA-domain synchroniser
// sees stable address and colour around each write-enable pulse.
//   clock       processor clock
//   reset       asynchronous, active-high
//   req         request handshake (slave side)
//   image_word  [31:24]=0, [23]=wEn, [22:15]=colour, [14:0]=address
//   busy        FIFO non-empty or a frame in progress
module vga_image_writer
    import vga_image_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                clock,
    input  logic                reset,
    vga_image_writer_if.slave   req,
    output logic [31:0]         image_word,
    output logic                busy
);

    localparam int unsigned CNT_MAX = max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [COLOR_W-1:0] r_color;
    logic [LEN_W-1:0]   r_rem;
    logic [31:0]        r_word;

    req_t               w_in;
    req_t               w_head;
    logic [REQ_W-1:0]   w_head_bits;
    logic               w_full;
    logic               w_empty;
    logic               w_last;
    logic               w_pop;
    logic [LEN_W-1:0]   w_head_rem;

    assign w_in = '{fill: req.req_fill, addr: req.req_addr,
                    color: req.req_color, len: req.req_len};

    sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (req.req_valid),
        .i_pop   (w_pop),
        .i_data  (w_in),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head     = req_t'(w_head_bits);
    assign w_head_rem = w_head.fill ? w_head.len : LEN_W'(1);
    assign w_last     = (r_cnt == '0);

    // The head is consumed either from IDLE or at the final GAP cycle of the
    // last pixel of the current request, which removes the IDLE bubble.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    (r_state == ST_GAP && w_last && r_rem == LEN_W'(1)));

    assign req.req_ready = !w_full;
    assign image_word    = r_word;
    assign busy          = !w_empty || (r_state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_color <= '0;
            r_rem   <= '0;
            r_word  <= '0;
        end else begin
            case (r_state)
                ST_SETUP: begin
                    if (w_last) begin
                        r_state         <= ST_ASSERT;
                        r_cnt           <= HOLD_LOAD;
                        r_word[WEN_BIT] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (w_last) begin
                        r_state         <= ST_GAP;
                        r_cnt           <= GAP_LOAD;
                        r_word[WEN_BIT] <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_last) begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem != LEN_W'(1)) begin
                            r_state <= ST_SETUP;
                            r_cnt   <= SETUP_LOAD;
                            r_addr  <= r_addr + 1'b1;
                            r_word  <= pack_word(1'b0, r_color, r_addr + 1'b1);
                        end else begin
                            r_state <= ST_IDLE;
                            r_word  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase

            // A pop overrides the transitions above: load the next request,
            // or drop a zero-length fill and rest in IDLE.
            if (w_pop) begin
                if (w_head_rem == '0) begin
                    r_state <= ST_IDLE;
                    r_word  <= '0;
                end else begin
                    r_state <= ST_SETUP;
                    r_cnt   <= SETUP_LOAD;
                    r_addr  <= w_head.addr;
                    r_color <= w_head.color;
                    r_rem   <= w_head_rem;
                    r_word  <= pack_word(1'b0, w_head.color, w_head.addr);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_image_writer.sv
// tb_vga_image_writer
// Directed frame checks plus random request traffic; a monitor compares each
// write-enable pulse against an expected pixel list expanded from accepted
// requests and checks frame timing / field stability.
module tb_vga_image_writer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SETUP = 2;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned GAP   = 2;
    localparam int unsigned PERIOD = SETUP + HOLD + GAP;

    logic        clock;
    logic        reset;
    logic [31:0] image_word;
    logic        busy;

    vga_image_writer_if bus();

    vga_image_writer #(
        .FIFO_DEPTH   (DEPTH),
        .SETUP_CYCLES (SETUP),
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (bus),
        .image_word (image_word),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned last_acc_cyc = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] prev_w   = '0;
    logic [31:0] mon_w;
    int unsigned run_len  = 0;
    int unsigned rise_q[$];
    logic [22:0] exp_q[$];   // {colour, address} of each pixel still owed

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: a request becomes a list of pixels, addresses wrapping at 15 bits.
    task automatic push_expected(input logic f, input logic [14:0] a, input logic [7:0] c,
                                 input logic [14:0] l);
        int unsigned n;
        logic [14:0] aa;
        n  = f ? int'(l) : 1;
        aa = a;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back({c, aa});
            aa = aa + 15'd1;
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (!mon_en || reset) begin
            prev_w  = '0;
            run_len = 0;
        end else begin
            mon_w = image_word;
            if (mon_w[23] && !prev_w[23]) begin
                check("rise_stable", {9'd0, mon_w[22:0]}, {9'd0, prev_w[22:0]});
                check("upper_zero", {24'd0, mon_w[31:24]}, 32'd0);
                rise_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", {9'd0, mon_w[22:0]}, 32'hFFFF_FFFF);
                end else begin
                    check("pixel", {9'd0, mon_w[22:0]}, {9'd0, exp_q.pop_front()});
                end
                run_len = 1;
            end else if (mon_w[23]) begin
                check("hold_stable", {9'd0, mon_w[22:0]}, {9'd0, prev_w[22:0]});
                run_len++;
            end else if (prev_w[23]) begin
                check("fall_stable", {9'd0, mon_w[22:0]}, {9'd0, prev_w[22:0]});
                check("hold_len", run_len, HOLD);
            end
            prev_w = mon_w;
        end
    end

    task automatic send(input logic f, input logic [14:0] a, input logic [7:0] c,
                        input logic [14:0] l);
        int unsigned waited;
        waited = 0;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_fill  = f;
        bus.req_addr  = a;
        bus.req_color = c;
        bus.req_len   = l;
        #1;
        while (!bus.req_ready && waited < 400) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!bus.req_ready) begin
            check("send_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            push_expected(f, a, c, l);
            last_acc_cyc = cyc;
            @(posedge clock);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k;
        k = 0;
        @(negedge clock);
        bus.req_valid = 1'b0;
        while (busy && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    logic [31:0] t1_exp [10];
    int unsigned first_acc;
    int unsigned k5;
    logic        f;
    logic [14:0] a;
    logic [7:0]  c;
    logic [14:0] l;

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_fill  = 1'b0;
        bus.req_addr  = '0;
        bus.req_color = '0;
        bus.req_len   = '0;
        #1;
        check("reset_word", image_word, 32'd0);
        check("reset_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1 mon_en = 1'b1;

        // Single write: exact frame shape.
        t1_exp = '{32'h0000_0000, 32'h002D_0123, 32'h002D_0123,
                   32'h00AD_0123, 32'h00AD_0123, 32'h00AD_0123, 32'h00AD_0123,
                   32'h002D_0123, 32'h002D_0123, 32'h0000_0000};
        send(1'b0, 15'h0123, 8'h5A, 15'd0);
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            check($sformatf("single_word%0d", i), image_word, t1_exp[i]);
        end
        check("single_busy_after", {31'd0, busy}, 32'd0);
        wait_idle("single");

        // Fill across the 15-bit address wrap.
        rise_q.delete();
        send(1'b1, 15'h7FFE, 8'h01, 15'd3);
        wait_idle("wrap");
        check("wrap_pulses", rise_q.size(), 32'd3);
        if (rise_q.size() == 3) begin
            for (int unsigned i = 1; i < 3; i++)
                check("wrap_period", rise_q[i] - rise_q[i-1], PERIOD);
        end

        // Five back-to-back singles into a 4-deep FIFO.
        rise_q.delete();
        send(1'b0, 15'h0100, 8'h40, 15'd0);
        first_acc = last_acc_cyc;
        for (int unsigned i = 1; i < 5; i++)
            send(1'b0, 15'(32'h100 + i), 8'(32'h40 + i), 15'd9);
        check("b2b_accept_span", last_acc_cyc - first_acc, 32'd4);
        @(negedge clock);
        bus.req_valid = 1'b0;
        #1;
        check("b2b_ready_full", {31'd0, bus.req_ready}, 32'd0);
        wait_idle("b2b");
        check("b2b_pulses", rise_q.size(), 32'd5);
        if (rise_q.size() == 5) begin
            for (int unsigned i = 1; i < 5; i++)
                check("b2b_period", rise_q[i] - rise_q[i-1], PERIOD);
        end

        // Zero-length fill followed by a single write.
        send(1'b1, 15'h0555, 8'h77, 15'd0);
        send(1'b0, 15'h0010, 8'h33, 15'd0);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("len0_idle", image_word, 32'd0);
        @(negedge clock);
        check("len0_next_setup", image_word, 32'h0019_8010);
        wait_idle("len0");

        // Reset in the middle of a long fill.
        send(1'b1, 15'h0200, 8'h11, 15'd10);
        @(negedge clock);
        bus.req_valid = 1'b0;
        k5 = 0;
        while (!image_word[23] && k5 < 100) begin
            @(negedge clock);
            k5++;
        end
        check("rst_wen_seen", {31'd0, image_word[23]}, 32'd1);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("rst_async_word", image_word, 32'd0);
        exp_q.delete();
        rise_q.delete();
        @(negedge clock);
        reset = 1'b0;
        #1 mon_en = 1'b1;
        repeat (40) @(negedge clock);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        check("rst_after_word", image_word, 32'd0);
        check("rst_after_pulses", rise_q.size(), 32'd0);

        // Random traffic against the pixel-list model.
        for (int unsigned n = 0; n < 80; n++) begin
            f = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0)
                a = 15'(32'h7FFC + $urandom_range(0, 3));
            else
                a = 15'($urandom);
            c = 8'($urandom);
            l = 15'($urandom_range(0, 5));
            send(f, a, c, l);
            idle($urandom_range(0, 2));
        end
        wait_idle("random");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
